stoch_stream_decoder: RTL and testbench

//  Converts a unipolar stochastic bitstream (e.g. stoch_square_root output) back to binary.
//  - Counts ones over a fixed window of 2**WINDOW_LOG2 valid bits.
//  - Presents each window count on a one-entry valid/ready output register.
//  - Sits at the exit of stochastic datapaths, feeding binary logic or a readback bus.

---
 rtl/stoch_stream_decoder.sv | 105 ++++++++++
 tb/tb_stoch_stream_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over windows of 2**WINDOW_LOG2 valid bits
// and presents each window count on a single-entry valid/ready output register.
module stoch_stream_decoder #(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter bit          CONTINUOUS  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 a,
  input  logic                 a_valid,
  input  logic                 start,
  input  logic                 clear,
  output logic [WINDOW_LOG2:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // State entered from reset and from clear depends on the windowing mode.
  localparam state_t RESTART_STATE = CONTINUOUS ? ACCUM : IDLE;

  state_t state;
  state_t state_nxt;

  logic [WINDOW_LOG2-1:0] bit_cnt;
  logic [WINDOW_LOG2:0]   ones_cnt;
  logic [WINDOW_LOG2:0]   ones_sum;
  logic                   sample;
  logic                   window_done;
  logic                   load_y;
  logic                   drop_y;
  logic                   take_y;

  always_comb begin
    sample      = (state == ACCUM) && a_valid && !clear;
    window_done = sample && (bit_cnt == '1);
    ones_sum    = ones_cnt + (WINDOW_LOG2 + 1)'(a);
    take_y      = y_valid && y_ready;
    // A completion may reuse the slot being drained in the same cycle.
    load_y      = window_done && (!y_valid || y_ready);
    drop_y      = window_done && y_valid && !y_ready;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = RESTART_STATE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = ACCUM;
        ACCUM:   if (window_done && !CONTINUOUS) state_nxt = IDLE;
        default: state_nxt = RESTART_STATE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RESTART_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (clear) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (sample) begin
      bit_cnt  <= bit_cnt + WINDOW_LOG2'(1);
      ones_cnt <= window_done ? '0 : ones_sum;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load_y) begin
        y       <= ones_sum;
        y_valid <= 1'b1;
      end else if (take_y) begin
        y_valid <= 1'b0;
      end
      if (drop_y) overrun <= 1'b1;
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_stoch_stream_decoder.sv
// Directed bench for stoch_stream_decoder: three instances cover N=256 continuous,
// N=16 continuous and N=16 single-shot, all sharing the same input drive.
module tb_stoch_stream_decoder;

  logic CLK;
  logic RST;
  logic a;
  logic a_valid;
  logic start;
  logic clear;
  logic y_ready;

  logic [8:0] y_l;
  logic       yv_l, busy_l, ov_l;
  logic [4:0] y_c;
  logic       yv_c, busy_c, ov_c;
  logic [4:0] y_s;
  logic       yv_s, busy_s, ov_s;

  int unsigned vectors;
  int unsigned miscompares;

  stoch_stream_decoder #(.WINDOW_LOG2(8), .CONTINUOUS(1'b1)) u_l256 (
    .CLK(CLK), .RST(RST), .a(a), .a_valid(a_valid), .start(start), .clear(clear),
    .y(y_l), .y_valid(yv_l), .y_ready(y_ready), .busy(busy_l), .overrun(ov_l)
  );

  stoch_stream_decoder #(.WINDOW_LOG2(4), .CONTINUOUS(1'b1)) u_c16 (
    .CLK(CLK), .RST(RST), .a(a), .a_valid(a_valid), .start(start), .clear(clear),
    .y(y_c), .y_valid(yv_c), .y_ready(y_ready), .busy(busy_c), .overrun(ov_c)
  );

  stoch_stream_decoder #(.WINDOW_LOG2(4), .CONTINUOUS(1'b0)) u_s16 (
    .CLK(CLK), .RST(RST), .a(a), .a_valid(a_valid), .start(start), .clear(clear),
    .y(y_s), .y_valid(yv_s), .y_ready(y_ready), .busy(busy_s), .overrun(ov_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step(input logic av, input logic aa);
    a_valid = av;
    a       = aa;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    a       = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    RST     = 1'b1;
    #2;
    RST     = 1'b0;
  endtask

  task automatic test_reset();
    a_valid = 1'b0; a = 1'b0; start = 1'b0; clear = 1'b0; y_ready = 1'b1;
    RST = 1'b1;
    #2;
    vectors++; if (y_l !== 9'h000) begin miscompares++; $display("FAIL reset_y_l256 got=%h exp=%h", y_l, 9'h000); end
    vectors++; if (yv_l !== 1'b0) begin miscompares++; $display("FAIL reset_yv_l256 got=%b exp=0", yv_l); end
    vectors++; if (ov_l !== 1'b0) begin miscompares++; $display("FAIL reset_ov_l256 got=%b exp=0", ov_l); end
    vectors++; if (busy_l !== 1'b1) begin miscompares++; $display("FAIL reset_busy_l256 got=%b exp=1", busy_l); end
    vectors++; if (y_c !== 5'd0) begin miscompares++; $display("FAIL reset_y_c16 got=%0d exp=0", y_c); end
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL reset_yv_c16 got=%b exp=0", yv_c); end
    vectors++; if (busy_c !== 1'b1) begin miscompares++; $display("FAIL reset_busy_c16 got=%b exp=1", busy_c); end
    vectors++; if (busy_s !== 1'b0) begin miscompares++; $display("FAIL reset_busy_s16 got=%b exp=0", busy_s); end
    vectors++; if (yv_s !== 1'b0) begin miscompares++; $display("FAIL reset_yv_s16 got=%b exp=0", yv_s); end
    vectors++; if (ov_s !== 1'b0) begin miscompares++; $display("FAIL reset_ov_s16 got=%b exp=0", ov_s); end
    RST = 1'b0;
  endtask

  // T1: all-ones input, N=256 back-to-back windows with a ready consumer.
  task automatic test_full_window();
    logic exp_v;
    do_reset();
    y_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b1);
      exp_v = ((i % 256) == 255);
      vectors++; if (yv_l !== exp_v) begin miscompares++; $display("FAIL t1_yvalid bit=%0d got=%b exp=%b", i, yv_l, exp_v); end
      if (exp_v) begin
        vectors++; if (y_l !== 9'h100) begin miscompares++; $display("FAIL t1_y bit=%0d got=%h exp=%h", i, y_l, 9'h100); end
      end
    end
    vectors++; if (ov_l !== 1'b0) begin miscompares++; $display("FAIL t1_overrun got=%b exp=0", ov_l); end
  endtask

  // T2: alternating valid, 1010 pattern on valid bits; invalid cycles carry a=1.
  task automatic test_sparse_valid();
    logic av;
    logic aa;
    do_reset();
    y_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      av = (c % 2) == 1;
      aa = av ? (((c / 2) % 2) == 0) : 1'b1;
      step(av, aa);
      if (c < 31) begin
        vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t2_early_valid cycle=%0d got=%b exp=0", c, yv_c); end
      end
    end
    vectors++; if (yv_c !== 1'b1) begin miscompares++; $display("FAIL t2_yvalid got=%b exp=1", yv_c); end
    vectors++; if (y_c !== 5'd8) begin miscompares++; $display("FAIL t2_y got=%0d exp=8", y_c); end
    step(1'b0, 1'b0);
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t2_pulse got=%b exp=0", yv_c); end
  endtask

  // T3: stalled consumer across two all-zero windows.
  task automatic test_overrun();
    do_reset();
    y_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    vectors++; if (yv_c !== 1'b1) begin miscompares++; $display("FAIL t3_w1_valid got=%b exp=1", yv_c); end
    vectors++; if (y_c !== 5'd0) begin miscompares++; $display("FAIL t3_w1_y got=%0d exp=0", y_c); end
    vectors++; if (ov_c !== 1'b0) begin miscompares++; $display("FAIL t3_w1_ov got=%b exp=0", ov_c); end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      vectors++; if (yv_c !== 1'b1 || y_c !== 5'd0) begin miscompares++; $display("FAIL t3_hold bit=%0d got=%b/%0d exp=1/0", i, yv_c, y_c); end
    end
    vectors++; if (ov_c !== 1'b1) begin miscompares++; $display("FAIL t3_w2_ov got=%b exp=1", ov_c); end
    y_ready = 1'b1;
    step(1'b0, 1'b0);
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t3_one_xfer got=%b exp=0", yv_c); end
    step(1'b0, 1'b0);
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t3_no_second got=%b exp=0", yv_c); end
    vectors++; if (ov_c !== 1'b1) begin miscompares++; $display("FAIL t3_sticky got=%b exp=1", ov_c); end
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
    vectors++; if (ov_c !== 1'b0) begin miscompares++; $display("FAIL t3_clear_ov got=%b exp=0", ov_c); end
  endtask

  // T4: window completes in the very cycle the previous result is accepted.
  task automatic test_back_to_back();
    do_reset();
    y_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b1 || y_c !== 5'd16) begin miscompares++; $display("FAIL t4_first got=%b/%0d exp=1/16", yv_c, y_c); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    vectors++; if (y_c !== 5'd16) begin miscompares++; $display("FAIL t4_held got=%0d exp=16", y_c); end
    y_ready = 1'b1;
    step(1'b1, 1'b0);
    vectors++; if (yv_c !== 1'b1) begin miscompares++; $display("FAIL t4_valid got=%b exp=1", yv_c); end
    vectors++; if (y_c !== 5'd0) begin miscompares++; $display("FAIL t4_newy got=%0d exp=0", y_c); end
    vectors++; if (ov_c !== 1'b0) begin miscompares++; $display("FAIL t4_ov got=%b exp=0", ov_c); end
    step(1'b0, 1'b0);
    vectors++; if (yv_c !== 1'b0 || y_c !== 5'd0) begin miscompares++; $display("FAIL t4_drain got=%b/%0d exp=0/0", yv_c, y_c); end
  endtask

  // T5: single-shot mode.
  task automatic test_single_shot();
    do_reset();
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    vectors++; if (busy_s !== 1'b0 || yv_s !== 1'b0) begin miscompares++; $display("FAIL t5_idle got=%b/%b exp=0/0", busy_s, yv_s); end
    start = 1'b1;
    step(1'b0, 1'b0);
    start = 1'b0;
    vectors++; if (busy_s !== 1'b1) begin miscompares++; $display("FAIL t5_busy got=%b exp=1", busy_s); end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    vectors++; if (yv_s !== 1'b1 || y_s !== 5'd16) begin miscompares++; $display("FAIL t5_result got=%b/%0d exp=1/16", yv_s, y_s); end
    vectors++; if (busy_s !== 1'b0) begin miscompares++; $display("FAIL t5_done got=%b exp=0", busy_s); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      vectors++; if (yv_s !== 1'b0 || busy_s !== 1'b0) begin miscompares++; $display("FAIL t5_no_restart bit=%0d got=%b/%b exp=0/0", i, yv_s, busy_s); end
    end
  endtask

  // T6a: clear part-way through a window discards the partial count.
  task automatic test_clear_mid();
    do_reset();
    y_ready = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    vectors++; if (yv_c !== 1'b0 || busy_c !== 1'b1) begin miscompares++; $display("FAIL t6_clear_state got=%b/%b exp=0/1", yv_c, busy_c); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t6_clear_early got=%b exp=0", yv_c); end
    step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b1 || y_c !== 5'd16) begin miscompares++; $display("FAIL t6_clear_y got=%b/%0d exp=1/16", yv_c, y_c); end
  endtask

  // T6b: asynchronous reset pulse in the middle of a window.
  task automatic test_async_reset();
    do_reset();
    y_ready = 1'b0;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
    start = 1'b1;
    step(1'b0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b1 || y_c !== 5'd16 || ov_c !== 1'b1) begin miscompares++; $display("FAIL t6_pre got=%b/%0d/%b exp=1/16/1", yv_c, y_c, ov_c); end
    vectors++; if (busy_s !== 1'b1) begin miscompares++; $display("FAIL t6_pre_busy got=%b exp=1", busy_s); end
    RST = 1'b1;
    #2;
    vectors++; if (y_c !== 5'd0 || yv_c !== 1'b0 || ov_c !== 1'b0) begin miscompares++; $display("FAIL t6_async got=%0d/%b/%b exp=0/0/0", y_c, yv_c, ov_c); end
    vectors++; if (busy_s !== 1'b0 || y_s !== 5'd0) begin miscompares++; $display("FAIL t6_async_s got=%b/%0d exp=0/0", busy_s, y_s); end
    vectors++; if (y_l !== 9'h000 || yv_l !== 1'b0) begin miscompares++; $display("FAIL t6_async_l got=%h/%b exp=000/0", y_l, yv_l); end
    RST = 1'b0;
    y_ready = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b0) begin miscompares++; $display("FAIL t6_post_early got=%b exp=0", yv_c); end
    step(1'b1, 1'b1);
    vectors++; if (yv_c !== 1'b1 || y_c !== 5'd16) begin miscompares++; $display("FAIL t6_post_y got=%b/%0d exp=1/16", yv_c, y_c); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_full_window();
    test_sparse_valid();
    test_overrun();
    test_back_to_back();
    test_single_shot();
    test_clear_mid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
